// File: rtl/axi_tagctrl_aw_if.sv
// AW-stage bundle: slave AW beat in, master AW beat out, write descriptor out.
// Signal suffixes are relative to the tag-controller AW stage.
interface axi_tagctrl_aw_if #(
    parameter int AxiAddrWidth = 64,
    parameter int AxiIdWidth   = 4
);
    logic [AxiAddrWidth-1:0] aw_slv_addr_i;
    logic [7:0]              aw_slv_len_i;
    logic [2:0]              aw_slv_size_i;
    logic [1:0]              aw_slv_burst_i;
    logic [AxiIdWidth-1:0]   aw_slv_id_i;
    logic                    aw_slv_valid_i;
    logic                    aw_slv_ready_o;

    logic [AxiAddrWidth-1:0] aw_mst_addr_o;
    logic [7:0]              aw_mst_len_o;
    logic [2:0]              aw_mst_size_o;
    logic [1:0]              aw_mst_burst_o;
    logic [AxiIdWidth-1:0]   aw_mst_id_o;
    logic                    aw_mst_valid_o;
    logic                    aw_mst_ready_i;

    logic [AxiAddrWidth-1:0] desc_addr_o;
    logic [7:0]              desc_len_o;
    logic [2:0]              desc_size_o;
    logic [1:0]              desc_burst_o;
    logic [AxiIdWidth-1:0]   desc_id_o;
    logic                    desc_valid_o;
    logic                    desc_ready_i;

    // The AW stage itself
    modport slave (
        input  aw_slv_addr_i, aw_slv_len_i, aw_slv_size_i, aw_slv_burst_i, aw_slv_id_i,
        input  aw_slv_valid_i, aw_mst_ready_i, desc_ready_i,
        output aw_slv_ready_o,
        output aw_mst_addr_o, aw_mst_len_o, aw_mst_size_o, aw_mst_burst_o, aw_mst_id_o,
        output aw_mst_valid_o,
        output desc_addr_o, desc_len_o, desc_size_o, desc_burst_o, desc_id_o, desc_valid_o
    );

    // Whatever surrounds the AW stage (upstream port, memory, W unit)
    modport master (
        output aw_slv_addr_i, aw_slv_len_i, aw_slv_size_i, aw_slv_burst_i, aw_slv_id_i,
        output aw_slv_valid_i, aw_mst_ready_i, desc_ready_i,
        input  aw_slv_ready_o,
        input  aw_mst_addr_o, aw_mst_len_o, aw_mst_size_o, aw_mst_burst_o, aw_mst_id_o,
        input  aw_mst_valid_o,
        input  desc_addr_o, desc_len_o, desc_size_o, desc_burst_o, desc_id_o, desc_valid_o
    );
endinterface

// File: rtl/axi_tagctrl_aw.sv
// CHERI tag controller write-address stage: forwards AW beats to memory, queues
// a write descriptor per beat for the W unit, and bounds outstanding writes.
module axi_tagctrl_aw #(
    parameter int AxiAddrWidth  = 64,
    parameter int AxiIdWidth    = 4,
    parameter int DescFifoDepth = 2,
    parameter int MaxWrTxns     = 4,
    localparam int CntW         = $clog2(MaxWrTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    axi_tagctrl_aw_if.slave     aw,
    input  logic                txn_done_i,
    output logic [CntW-1:0]     outstanding_o
);
    localparam int PtrW  = (DescFifoDepth > 1) ? $clog2(DescFifoDepth) : 1;
    localparam int FillW = $clog2(DescFifoDepth + 1);

    typedef enum logic {IDLE, FWD} state_e;

    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [AxiIdWidth-1:0]   id;
    } beat_t;

    state_e           state_q, state_d;
    beat_t            beat_q, beat_d;
    logic             aw_pend_q, aw_pend_d;
    logic             desc_pend_q, desc_pend_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    beat_t            mem_q [DescFifoDepth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0] fill_q;

    logic fifo_full, fifo_empty, slv_hs, push, pop, done_ok;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DescFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Full is taken from the registered fill level, so a same-cycle pop never frees space for a push
    assign fifo_full  = (fill_q == FillW'(DescFifoDepth));
    assign fifo_empty = (fill_q == '0);
    assign aw.aw_slv_ready_o = (state_q == IDLE) && !rst_i && (cnt_q < CntW'(MaxWrTxns)) && !fifo_full;
    assign slv_hs  = aw.aw_slv_ready_o && aw.aw_slv_valid_i;
    assign push    = (state_q == FWD) && desc_pend_q && !fifo_full;
    assign pop     = !fifo_empty && aw.desc_ready_i;
    assign done_ok = txn_done_i && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        aw_pend_d   = aw_pend_q;
        desc_pend_d = desc_pend_q;
        case (state_q)
            IDLE: begin
                if (slv_hs) begin
                    beat_d.addr  = aw.aw_slv_addr_i;
                    beat_d.len   = aw.aw_slv_len_i;
                    beat_d.size  = aw.aw_slv_size_i;
                    beat_d.burst = aw.aw_slv_burst_i;
                    beat_d.id    = aw.aw_slv_id_i;
                    aw_pend_d    = 1'b1;
                    desc_pend_d  = 1'b1;
                    state_d      = FWD;
                end
            end
            FWD: begin
                if (push)              desc_pend_d = 1'b0;
                if (aw.aw_mst_ready_i) aw_pend_d   = 1'b0;
                if (!aw_pend_d && !desc_pend_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({slv_hs, done_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            aw_pend_q   <= 1'b0;
            desc_pend_q <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            for (int i = 0; i < DescFifoDepth; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            aw_pend_q   <= aw_pend_d;
            desc_pend_q <= desc_pend_d;
            cnt_q       <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= beat_q;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FillW'(1);
                2'b01:   fill_q <= fill_q - FillW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign aw.aw_mst_valid_o = aw_pend_q;
    assign aw.aw_mst_addr_o  = beat_q.addr;
    assign aw.aw_mst_len_o   = beat_q.len;
    assign aw.aw_mst_size_o  = beat_q.size;
    assign aw.aw_mst_burst_o = beat_q.burst;
    assign aw.aw_mst_id_o    = beat_q.id;

    assign aw.desc_valid_o = !fifo_empty;
    assign aw.desc_addr_o  = mem_q[rd_ptr_q].addr;
    assign aw.desc_len_o   = mem_q[rd_ptr_q].len;
    assign aw.desc_size_o  = mem_q[rd_ptr_q].size;
    assign aw.desc_burst_o = mem_q[rd_ptr_q].burst;
    assign aw.desc_id_o    = mem_q[rd_ptr_q].id;

    assign outstanding_o = cnt_q;
endmodule

// File: doc/axi_tagctrl_aw.md
Name: axi_tagctrl_aw

Overview:
Write-address stage of the CHERI tag controller, directly upstream of the W-channel tag unit. Accepts AXI AW beats from the slave port, forwards each unchanged to the master (memory) port, and pushes a matching write descriptor (addr, size, len, id, burst) into a descriptor FIFO. The W-channel unit pops that FIFO. Outstanding write transactions are counted and bounded, and are retired by a completion pulse from the W-channel unit.

Parameters:
AxiAddrWidth, 64, AW address width in bits.
AxiIdWidth, 4, AW ID width in bits.
DescFifoDepth, 2, descriptor FIFO entries (>=1).
MaxWrTxns, 4, maximum outstanding write transactions (>=1).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
aw_slv_addr_i  in  AxiAddrWidth  slave AW address.
aw_slv_len_i  in  8  slave AW burst length minus one.
aw_slv_size_i  in  3  slave AW beat size (log2 bytes).
aw_slv_burst_i  in  2  slave AW burst type.
aw_slv_id_i  in  AxiIdWidth  slave AW ID.
aw_slv_valid_i  in  1  slave AW valid.
aw_slv_ready_o  out  1  slave AW ready.
aw_mst_addr_o / len_o / size_o / burst_o / id_o  out  same widths  master AW payload.
aw_mst_valid_o  out  1  master AW valid.
aw_mst_ready_i  in  1  master AW ready.
desc_addr_o / len_o / size_o / burst_o / id_o  out  same widths  descriptor payload to W unit.
desc_valid_o  out  1  descriptor FIFO not empty.
desc_ready_i  in  1  W unit pops descriptor.
txn_done_i  in  1  one-cycle pulse: W unit completed a B handshake to slave.
outstanding_o  out  $clog2(MaxWrTxns+1)  current outstanding count.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; aw_slv_ready_o=0, aw_mst_valid_o=0, desc_valid_o=0, outstanding_o=0, FIFO empty, payload registers 0. Reset mid-transaction discards the held AW and all FIFO contents. The next cycle after reset deasserts is IDLE.
- FSM has two states: IDLE and FWD.
- IDLE:
  - aw_slv_ready_o = (outstanding < MaxWrTxns) && !fifo_full. This is combinational and is held 0 during reset.
  - On an AW handshake: register the payload, increment outstanding, set aw_pend=1 and desc_pend=1, and go to FWD.
- FWD:
  - aw_slv_ready_o=0.
  - aw_mst_valid_o=aw_pend, with registered payload bit-identical to the slave beat. aw_mst_valid_o, once asserted, holds until aw_mst_ready_i.
  - When desc_pend=1 and the FIFO is not full, push the descriptor in that cycle and clear desc_pend.
  - When aw_mst_ready_i=1, clear aw_pend.
  - Return to IDLE in the cycle where both pending flags are (or become) 0. Minimum slave-to-slave AW spacing is therefore 2 cycles; AW latency slave->master is 1 cycle.
- Descriptor FIFO:
  - Not fall-through: a pushed descriptor appears on desc_*_o in the next cycle.
  - Pop when desc_valid_o && desc_ready_i.
  - Push and pop in the same cycle when full is allowed only if the pop is registered first. Full is evaluated before the pop, so push is stalled when full even if a pop occurs.
  - Order is strictly FIFO; descriptor i corresponds to the i-th master AW.
- Outstanding counter:
  - +1 on slave AW handshake, -1 on txn_done_i. Both in the same cycle leaves it unchanged.
  - txn_done_i while count is 0 is ignored (saturate at 0). It never exceeds MaxWrTxns.
- No burst filtering: FIXED, INCR and WRAP are forwarded and described unchanged. The addr field is the unaligned start address.
- aw_slv_ready_o does not depend on aw_slv_valid_i (no combinational valid->ready path).

Test Plan:
- Single AW: addr=0x8000_0010, len=3, size=3, INCR, id=2 in IDLE, mst ready=1 -> master AW the next cycle with identical fields. Descriptor valid 2 cycles after the slave handshake with the same fields. outstanding_o=1.
- Master backpressure: aw_mst_ready_i=0 for 5 cycles -> aw_mst_valid_o stable with constant payload and aw_slv_ready_o=0 throughout. The descriptor is still pushed in FWD cycle 1. Returns to IDLE the cycle after the ready handshake.
- Outstanding limit: MaxWrTxns=4, 4 AWs with no txn_done_i -> aw_slv_ready_o=0 after the 4th. One txn_done_i pulse -> count 3 and ready=1 the next cycle.
- FIFO full: DescFifoDepth=2, desc_ready_i=0, 3 AWs -> the 3rd is blocked at IDLE ready=0. Popping one -> ready returns, and descriptors emerge in order id 0,1,2.
- Simultaneous: slave AW handshake and txn_done_i in the same cycle at count 2 -> count stays 2. txn_done_i at count 0 -> stays 0.
- Reset mid-FWD: rst_i=1 while aw_mst_valid_o=1 and FIFO holds 1 entry -> the next cycle shows all valids 0, outstanding 0 and FIFO empty.
